fb_scan_reader: RTL and testbench
=================================

# fb_scan_reader

Single-clock framebuffer-stream consumer: the read-side counterpart of the scanline writer. It accepts the framebuffer pixel stream (start/rgb/datavalid with ready backpressure), locks onto frame boundaries, buffers pixels in a FIFO, and delivers them one per read request to the pixel/video-timing side with frame-start tagging and underrun reporting. It sits between the framebuffer read path and the video mixer's pixel output stage.

## Interface
Parameters:
- WIDTH, 15, pixel width (RGB555)
- H_ACTIVE, 320, pixels per line
- V_ACTIVE, 240, lines per frame
- FIFO_AW, 9, FIFO address width; depth DEPTH = 2^FIFO_AW

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- iCLK  in  1  clock for all logic.
- iRESET_N  in  1  asynchronous active-low reset.
- iFB_START  in  1  marks the first pixel of a frame; qualified by iFB_DATAVALID.
- iFB_RGB  in  WIDTH  stream pixel.
- iFB_DATAVALID  in  1  stream beat valid.
- oFB_READY  out  1  the block can accept a beat; a beat transfers when iFB_DATAVALID && oFB_READY.
- iPIX_FRAME  in  1  one-cycle pulse from the timing generator at the start of the output frame.
- iPIX_READ  in  1  request for the next pixel.
- oPIX_RGB  out  WIDTH  delivered pixel (registered).
- oPIX_VALID  out  1  oPIX_RGB holds a real FIFO pixel.
- oPIX_START  out  1  delivered pixel is the first pixel of a frame.
- oPIX_UNDERRUN  out  1  one-cycle pulse: a read found no usable data.
- oLOCKED  out  1  the input side is in the RUN state.

## Operation
- FIFO entries are {start_tag, rgb}, WIDTH+1 bits wide. Occupancy is count in the range 0..DEPTH.
- oFB_READY = (count != DEPTH). This signal is combinational from registered state.
- Input FSM, with frame counter fcnt of 17 bits (range 0..H_ACTIVE*V_ACTIVE):
  - SYNC:
    - Accepted beats with iFB_START=0 are discarded; nothing is written.
    - An accepted beat with iFB_START=1 is written with tag=1, sets fcnt=1, and moves the FSM to RUN.
  - RUN:
    - Each accepted beat is written with tag=iFB_START, and fcnt increments.
    - Early start: iFB_START=1 while fcnt != H_ACTIVE*V_ACTIVE. The beat is written with tag=1 and fcnt is set to 1; the FSM stays in RUN.
    - Missing start: fcnt == H_ACTIVE*V_ACTIVE and the accepted beat has iFB_START=0. The beat is discarded and the FSM goes to SYNC.
    - Expected start: fcnt == H_ACTIVE*V_ACTIVE and iFB_START=1. The beat is written with tag=1 and fcnt is set to 1.
  - oLOCKED = (state == RUN).
- Output FSM:
  - NORMAL:
    - When iPIX_READ=1 and count>0, pop the head. Next cycle: oPIX_RGB=head.rgb, oPIX_START=head.tag, oPIX_VALID=1.
    - When iPIX_READ=1 and count==0, do not pop. Next cycle: oPIX_RGB=0, oPIX_VALID=0, oPIX_START=0, and oPIX_UNDERRUN=1.
    - When iPIX_READ=0, the output registers hold their values and oPIX_VALID drops to 0.
  - iPIX_FRAME=1, in any state → ALIGN.
  - ALIGN:
    - Every cycle, if the head exists with tag=0, pop and discard it, one entry per cycle, regardless of iPIX_READ.
    - If the head has tag=1, return to NORMAL without popping. A read in that same cycle is serviced as in NORMAL.
    - Any iPIX_READ seen while still aligning returns oPIX_RGB=0, oPIX_VALID=0, and pulses oPIX_UNDERRUN.
    - An empty FIFO in ALIGN stays in ALIGN.
- Simultaneous write and pop in one cycle: count is unchanged. A write into a full FIFO cannot occur because oFB_READY=0.
- iPIX_FRAME arriving in the same cycle as iPIX_READ: that read is handled as an ALIGN read.

## Timing
- Reset values:
  - count=0 and input FSM=SYNC, so oFB_READY=1 and oLOCKED=0.
  - Output FSM=NORMAL.
  - oPIX_RGB=0, oPIX_VALID=0, oPIX_START=0, oPIX_UNDERRUN=0.
- Reset is asynchronous mid-frame: the FIFO is flushed (pointers cleared) and the block resyncs on the next iFB_START.
- Read latency is 1 cycle: the iPIX_READ edge is followed by valid oPIX_* on the next edge.
- A write becomes visible to the read side 1 cycle after acceptance (no fall-through on the same edge).
- oFB_READY deasserts in the cycle after the write that makes count reach DEPTH. It reasserts in the cycle after the first pop from a full FIFO.
- Pointers wrap modulo DEPTH, and count tracks occupancy.
- Sustained throughput is 1 beat per cycle in and 1 pixel per cycle out.

## Test plan
- Sync: feed 5 beats with start=0, then frame 0x0000.., start on pixel 0 → the first 5 beats are dropped, oLOCKED rises the cycle after the start beat, and the first read returns 0x0000 with oPIX_START=1.
- Full frame loop: continuous counter stream of 76800 pixels, repeated for 2 frames, with reads every cycle → output equals input order, and oPIX_START=1 exactly at pixels 0 and 76800.
- Backpressure: no reads with 600 beats offered, DEPTH=512 → exactly 512 accepted and oFB_READY=0. Then 1 read → oFB_READY=1 on the next cycle and beat 513 is accepted.
- Underrun: read from an empty FIFO → oPIX_UNDERRUN pulses for 1 cycle and oPIX_VALID=0.
- Missing start: after 76800 pixels, send beat 0x1234 with start=0 → it is dropped and oLOCKED=0; the next start beat relocks.
- Frame align: 10 untagged pixels are queued ahead of a start pixel, then iPIX_FRAME → 10 discard cycles, after which the next read returns the start pixel with oPIX_START=1.
- Reset mid-frame: reset → the outputs return to their reset values and the FIFO is empty.

Source files
------------

// File: rtl/fb_scan_reader.sv
// Framebuffer stream consumer: locks onto frame starts, buffers {start_tag, rgb}
// in a FIFO and hands pixels out one per read, with frame alignment and underrun flags.
module fb_scan_reader #(
   parameter int WIDTH    = 15,
   parameter int H_ACTIVE = 320,
   parameter int V_ACTIVE = 240,
   parameter int FIFO_AW  = 9
) (
   input  logic             iCLK,
   input  logic             iRESET_N,
   input  logic             iFB_START,
   input  logic [WIDTH-1:0] iFB_RGB,
   input  logic             iFB_DATAVALID,
   output logic             oFB_READY,
   input  logic             iPIX_FRAME,
   input  logic             iPIX_READ,
   output logic [WIDTH-1:0] oPIX_RGB,
   output logic             oPIX_VALID,
   output logic             oPIX_START,
   output logic             oPIX_UNDERRUN,
   output logic             oLOCKED
);

   localparam int               DEPTH     = 1 << FIFO_AW;
   localparam logic [16:0]      FRAME_PIX = 17'(H_ACTIVE * V_ACTIVE);
   localparam logic [FIFO_AW:0] FULL      = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic {IN_SYNC, IN_RUN} in_state_t;
   typedef enum logic {OUT_NORMAL, OUT_ALIGN} out_state_t;

   in_state_t  in_state_q, in_state_d;
   out_state_t out_state_q, out_state_d;

   logic [WIDTH:0]     mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic [16:0]        fcnt_q, fcnt_d;

   logic [WIDTH-1:0] pix_rgb_q, pix_rgb_d;
   logic             pix_valid_q, pix_valid_d;
   logic             pix_start_q, pix_start_d;
   logic             pix_underrun_q, pix_underrun_d;

   logic             accept;
   logic             wr_en;
   logic             wr_tag;
   logic             pop;
   logic             has_data;
   logic             head_tag;
   logic [WIDTH-1:0] head_rgb;
   logic             align_now;
   logic             deliver;
   logic             discard;

   assign oFB_READY = (count_q != FULL);
   assign accept    = iFB_DATAVALID && oFB_READY;
   assign has_data  = (count_q != '0);
   assign head_tag  = mem_q[rd_ptr_q][WIDTH];
   assign head_rgb  = mem_q[rd_ptr_q][WIDTH-1:0];
   // A frame pulse makes its own cycle behave as an ALIGN cycle.
   assign align_now = iPIX_FRAME || (out_state_q == OUT_ALIGN);

   assign oLOCKED       = (in_state_q == IN_RUN);
   assign oPIX_RGB      = pix_rgb_q;
   assign oPIX_VALID    = pix_valid_q;
   assign oPIX_START    = pix_start_q;
   assign oPIX_UNDERRUN = pix_underrun_q;

   always_ff @(posedge iCLK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         in_state_q  <= IN_SYNC;
         out_state_q <= OUT_NORMAL;
      end else begin
         in_state_q  <= in_state_d;
         out_state_q <= out_state_d;
      end
   end

   always_comb begin
      in_state_d = in_state_q;
      case (in_state_q)
         IN_SYNC: if (accept && iFB_START) in_state_d = IN_RUN;
         IN_RUN:  if (accept && !iFB_START && (fcnt_q == FRAME_PIX)) in_state_d = IN_SYNC;
         default: in_state_d = IN_SYNC;
      endcase
      out_state_d = OUT_NORMAL;
      if (align_now && !(has_data && head_tag)) out_state_d = OUT_ALIGN;
   end

   always_comb begin
      wr_en  = 1'b0;
      wr_tag = 1'b0;
      fcnt_d = fcnt_q;
      if (accept) begin
         if (iFB_START) begin
            wr_en  = 1'b1;
            wr_tag = 1'b1;
            fcnt_d = 17'd1;
         end else if ((in_state_q == IN_RUN) && (fcnt_q != FRAME_PIX)) begin
            wr_en  = 1'b1;
            fcnt_d = fcnt_q + 17'd1;
         end
      end
   end

   always_comb begin
      deliver        = iPIX_READ && has_data && (!align_now || head_tag);
      discard        = align_now && has_data && !head_tag;
      pop            = deliver || discard;
      pix_rgb_d      = pix_rgb_q;
      pix_start_d    = pix_start_q;
      pix_valid_d    = 1'b0;
      pix_underrun_d = 1'b0;
      if (deliver) begin
         pix_rgb_d   = head_rgb;
         pix_start_d = head_tag;
         pix_valid_d = 1'b1;
      end else if (iPIX_READ) begin
         pix_rgb_d      = '0;
         pix_start_d    = 1'b0;
         pix_underrun_d = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(wr_en);
      rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
      count_d  = count_q + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(pop);
   end

   always_ff @(posedge iCLK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         fcnt_q         <= '0;
         pix_rgb_q      <= '0;
         pix_valid_q    <= 1'b0;
         pix_start_q    <= 1'b0;
         pix_underrun_q <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         fcnt_q         <= fcnt_d;
         pix_rgb_q      <= pix_rgb_d;
         pix_valid_q    <= pix_valid_d;
         pix_start_q    <= pix_start_d;
         pix_underrun_q <= pix_underrun_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge iCLK) begin
      if (wr_en) mem_q[wr_ptr_q] <= {wr_tag, iFB_RGB};
   end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader: scenario tasks plus a queue-based reference model
// of the stream rules, compared against the DUT every cycle.
module tb_fb_scan_reader;

   localparam int W     = 15;
   localparam int H     = 8;
   localparam int V     = 4;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int FRAME = H * V;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         fb_start, fb_dv, pix_frame, pix_read;
   logic [W-1:0] fb_rgb;
   logic         fb_ready, pix_valid, pix_start, pix_und, locked;
   logic [W-1:0] pix_rgb;

   fb_scan_reader #(.WIDTH(W), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_AW(AW)) dut (
      .iCLK(clk), .iRESET_N(rst_n),
      .iFB_START(fb_start), .iFB_RGB(fb_rgb), .iFB_DATAVALID(fb_dv), .oFB_READY(fb_ready),
      .iPIX_FRAME(pix_frame), .iPIX_READ(pix_read),
      .oPIX_RGB(pix_rgb), .oPIX_VALID(pix_valid), .oPIX_START(pix_start),
      .oPIX_UNDERRUN(pix_und), .oLOCKED(locked)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [W:0]   m_q[$];
   bit           m_locked, m_align;
   int           m_fcnt;
   logic [W-1:0] e_rgb;
   logic         e_valid, e_start, e_und;

   wire [W+4:0] act = {pix_rgb, pix_valid, pix_start, pix_und, fb_ready, locked};
   localparam logic [W+4:0] RESET_VEC = {{W{1'b0}}, 3'b000, 1'b1, 1'b0};

   function automatic logic [W+4:0] expv();
      logic rdy;
      logic lk;
      rdy = (m_q.size() != DEPTH);
      lk  = m_locked;
      return {e_rgb, e_valid, e_start, e_und, rdy, lk};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_locked = 0; m_align = 0; m_fcnt = 0;
      e_rgb = '0; e_valid = 0; e_start = 0; e_und = 0;
   endtask

   // Advance the model by one clock with the current inputs, then clock the DUT.
   task automatic cycle();
      logic [W:0] head;
      bit have, aligning, acc;
      acc      = fb_dv && (m_q.size() != DEPTH);
      have     = (m_q.size() > 0);
      head     = have ? m_q[0] : '0;
      aligning = m_align || pix_frame;
      e_valid  = 0;
      e_und    = 0;
      if (aligning && have && !head[W]) begin
         void'(m_q.pop_front());
         m_align = 1;
         if (pix_read) begin e_rgb = '0; e_start = 0; e_und = 1; end
      end else begin
         if (aligning) m_align = !have;
         if (pix_read) begin
            if (have) begin
               void'(m_q.pop_front());
               e_rgb = head[W-1:0]; e_start = head[W]; e_valid = 1;
            end else begin
               e_rgb = '0; e_start = 0; e_und = 1;
            end
         end
      end
      if (acc) begin
         if (fb_start) begin
            m_q.push_back({1'b1, fb_rgb}); m_locked = 1; m_fcnt = 1;
         end else if (m_locked && m_fcnt == FRAME) begin
            m_locked = 0;
         end else if (m_locked) begin
            m_q.push_back({1'b0, fb_rgb}); m_fcnt++;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic dv, input logic st, input logic [W-1:0] rgb,
                        input logic rd, input logic fr);
      fb_dv = dv; fb_start = st; fb_rgb = rgb; pix_read = rd; pix_frame = fr;
      cycle();
   endtask

   task automatic do_reset();
      fb_dv = 0; fb_start = 0; fb_rgb = '0; pix_read = 0; pix_frame = 0;
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (act !== RESET_VEC) begin
         n_fail++; $display("FAIL reset_state: got %h want %h", act, RESET_VEC);
      end
   endtask

   task automatic test_sync();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, W'($urandom()), 0, 0);
         n_tests++;
         if (act !== expv() || locked !== 1'b0) begin
            n_fail++; $display("FAIL sync_drop%0d: got %h want %h", i, act, expv());
         end
      end
      drive(1, 1, '0, 0, 0);
      n_tests++;
      if (locked !== 1'b1) begin
         n_fail++; $display("FAIL sync_lock: got %0b want 1", locked);
      end
      for (int i = 1; i < 6; i++) drive(1, 0, W'(i), 0, 0);
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, '0, 1, 0);
         n_tests++;
         if (pix_rgb !== W'(i) || pix_valid !== 1'b1 || pix_start !== (i == 0)) begin
            n_fail++; $display("FAIL sync_read%0d: got rgb %h v%0b s%0b want rgb %h v1 s%0b",
                               i, pix_rgb, pix_valid, pix_start, W'(i), (i == 0));
         end
      end
   endtask

   task automatic test_frame_loop();
      logic [W:0] got[$];
      int bad_order, bad_start, guard;
      do_reset();
      bad_order = 0;
      for (int s = 0; s < 2 * FRAME; s++) begin
         drive(1, (s % FRAME) == 0, W'(s + 3), 1, 0);
         n_tests++;
         if (act !== expv()) begin
            n_fail++; $display("FAIL loop_cycle%0d: got %h want %h", s, act, expv());
         end
         if (pix_valid) got.push_back({pix_start, pix_rgb});
      end
      guard = 0;
      while (got.size() < 2 * FRAME && guard < 50) begin
         drive(0, 0, '0, 1, 0);
         if (pix_valid) got.push_back({pix_start, pix_rgb});
         guard++;
      end
      n_tests++;
      if (got.size() != 2 * FRAME) begin
         n_fail++; $display("FAIL loop_count: got %0d want %0d", got.size(), 2 * FRAME);
      end
      bad_start = 0;
      for (int i = 0; i < got.size(); i++) begin
         if (got[i][W-1:0] !== W'(i + 3)) bad_order++;
         if (got[i][W] !== ((i % FRAME) == 0)) bad_start++;
      end
      n_tests++;
      if (bad_order != 0 || bad_start != 0) begin
         n_fail++; $display("FAIL loop_order: got %0d/%0d bad pixels/tags want 0/0", bad_order, bad_start);
      end
   endtask

   task automatic test_backpressure();
      int acc;
      do_reset();
      acc = 0;
      for (int i = 0; i < DEPTH + 8; i++) begin
         if (fb_ready) acc++;
         drive(1, i == 0, W'(i), 0, 0);
         n_tests++;
         if (act !== expv()) begin
            n_fail++; $display("FAIL bp_cycle%0d: got %h want %h", i, act, expv());
         end
      end
      n_tests++;
      if (acc != DEPTH || fb_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_full: got acc %0d ready %0b want %0d ready 0", acc, fb_ready, DEPTH);
      end
      drive(0, 0, '0, 1, 0);
      n_tests++;
      if (fb_ready !== 1'b1 || pix_rgb !== '0 || pix_start !== 1'b1 || pix_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_read: got ready %0b rgb %h s%0b v%0b want 1 0000 1 1",
                            fb_ready, pix_rgb, pix_start, pix_valid);
      end
      drive(1, 0, W'(16'h1abc), 0, 0);
      n_tests++;
      if (fb_ready !== 1'b0 || act !== expv()) begin
         n_fail++; $display("FAIL bp_refill: got %h want %h", act, expv());
      end
   endtask

   task automatic test_underrun();
      do_reset();
      drive(0, 0, '0, 1, 0);
      n_tests++;
      if (pix_und !== 1'b1 || pix_valid !== 1'b0) begin
         n_fail++; $display("FAIL underrun_pulse: got und %0b v%0b want 1 0", pix_und, pix_valid);
      end
      drive(0, 0, '0, 0, 0);
      n_tests++;
      if (pix_und !== 1'b0) begin
         n_fail++; $display("FAIL underrun_clear: got %0b want 0", pix_und);
      end
   endtask

   task automatic test_missing_start();
      int seen_bad, guard;
      bit seen_new;
      do_reset();
      seen_bad = 0;
      for (int s = 0; s < FRAME; s++) begin
         drive(1, s == 0, W'(s + 16'h100), 1, 0);
         if (pix_valid && pix_rgb === W'(16'h1234)) seen_bad++;
      end
      drive(1, 0, W'(16'h1234), 1, 0);
      n_tests++;
      if (locked !== 1'b0 || act !== expv()) begin
         n_fail++; $display("FAIL miss_unlock: got %h want %h", act, expv());
      end
      drive(1, 1, W'(16'h0777), 1, 0);
      n_tests++;
      if (locked !== 1'b1) begin
         n_fail++; $display("FAIL miss_relock: got %0b want 1", locked);
      end
      seen_new = 0; guard = 0;
      while (!seen_new && guard < 10) begin
         drive(0, 0, '0, 1, 0);
         if (pix_valid && pix_rgb === W'(16'h1234)) seen_bad++;
         if (pix_valid && pix_rgb === W'(16'h0777) && pix_start === 1'b1) seen_new = 1;
         guard++;
      end
      n_tests++;
      if (!seen_new || seen_bad != 0) begin
         n_fail++; $display("FAIL miss_stream: got relock_px %0b dropped_seen %0d want 1 0", seen_new, seen_bad);
      end
   endtask

   task automatic test_frame_align();
      do_reset();
      drive(1, 1, W'(16'h500), 0, 0);
      for (int k = 1; k <= 10; k++) drive(1, 0, W'(16'h500 + k), 0, 0);
      drive(1, 1, W'(16'h600), 0, 0);
      drive(0, 0, '0, 1, 0);
      n_tests++;
      if (pix_rgb !== W'(16'h500) || pix_start !== 1'b1) begin
         n_fail++; $display("FAIL align_first: got %h s%0b want 0500 s1", pix_rgb, pix_start);
      end
      drive(0, 0, '0, 0, 1);
      drive(0, 0, '0, 1, 0);
      n_tests++;
      if (pix_und !== 1'b1 || pix_valid !== 1'b0 || pix_rgb !== '0) begin
         n_fail++; $display("FAIL align_read_und: got und %0b v%0b rgb %h want 1 0 0000",
                            pix_und, pix_valid, pix_rgb);
      end
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, '0, 0, 0);
         n_tests++;
         if (act !== expv()) begin
            n_fail++; $display("FAIL align_cycle%0d: got %h want %h", i, act, expv());
         end
      end
      drive(0, 0, '0, 1, 0);
      n_tests++;
      if (pix_rgb !== W'(16'h600) || pix_start !== 1'b1 || pix_valid !== 1'b1) begin
         n_fail++; $display("FAIL align_start: got %h s%0b v%0b want 0600 s1 v1",
                            pix_rgb, pix_start, pix_valid);
      end
   endtask

   task automatic test_random();
      int rd_pct;
      do_reset();
      for (int i = 0; i < 1200; i++) begin
         rd_pct = (i / 150) % 2 == 0 ? 30 : 90;
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, W'($urandom()),
               $urandom_range(0, 99) < rd_pct, $urandom_range(0, 59) == 0);
         n_tests++;
         if (act !== expv()) begin
            n_fail++; $display("FAIL random_cycle%0d: got %h want %h", i, act, expv());
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1, 1, W'(16'h2aa), 0, 0);
      for (int i = 0; i < 5; i++) drive(1, 0, W'(i + 16'h2ab), 0, 0);
      drive(0, 0, '0, 1, 0);
      n_tests++;
      if (pix_valid !== 1'b1 || locked !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_pre: got v%0b lk%0b want 1 1", pix_valid, locked);
      end
      pix_read = 0;
      #2 rst_n = 0;
      #1;
      model_reset();
      n_tests++;
      if (act !== RESET_VEC) begin
         n_fail++; $display("FAIL rstmid_async: got %h want %h", act, RESET_VEC);
      end
      @(posedge clk); #1 rst_n = 1;
      drive(0, 0, '0, 1, 0);
      n_tests++;
      if (pix_und !== 1'b1 || pix_valid !== 1'b0 || act !== expv()) begin
         n_fail++; $display("FAIL rstmid_empty: got %h want %h", act, expv());
      end
   endtask

   initial begin
      rst_n = 0;
      fb_dv = 0; fb_start = 0; fb_rgb = '0; pix_read = 0; pix_frame = 0;
      model_reset();
      test_reset();
      test_sync();
      test_frame_loop();
      test_backpressure();
      test_underrun();
      test_missing_start();
      test_frame_align();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
